countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Programmable down-counting timer with a prescaler, start/stop control, optional auto-reload and a sticky interrupt flag.
- It is the down-counting counterpart of the team's up counter.
- Provides delays and periodic ticks for the 16-bit RISC core's control and peripheral logic.
- Single clock domain.

Parameters:
WIDTH, 16, width of the count and reload value
PRESCALE_W, 8, width of the prescaler divide field

Ports:
CLK  input  1  clock; all state changes on the rising edge
RST  input  1  reset, synchronous, active-high
EN  input  1  global enable; 0 freezes the prescaler and COUNT
LOAD  input  1  load LOAD_VAL into the reload register and COUNT
LOAD_VAL  input  WIDTH  value to load
PRESCALE  input  PRESCALE_W  divide ratio minus 1 (tick every PRESCALE+1 enabled cycles)
AUTO_RELOAD  input  1  1 = reload and keep running on expiry; 0 = one-shot
START  input  1  begin or resume counting
STOP  input  1  pause counting; COUNT holds
IRQ_ACK  input  1  clears IRQ
COUNT  output  WIDTH  current count
BUSY  output  1  1 while in RUN
TC  output  1  terminal-count pulse, one cycle wide
IRQ  output  1  sticky expiry flag

Behaviour:
- Reset (RST=1 at an edge): COUNT=0, reload register=0, prescaler=0, state=IDLE, BUSY=0, TC=0, IRQ=0. Reset overrides every other input, including mid-run.
- States:
  - IDLE (BUSY=0)
  - RUN (BUSY=1)
- Priority within a cycle: RST > LOAD > STOP > START > tick.
- LOAD, accepted in any state:
  - reload register = LOAD_VAL, COUNT = LOAD_VAL, prescaler cleared.
  - State is unchanged, except LOAD_VAL=0 in RUN forces IDLE.
  - No TC is generated.
- START in IDLE:
  - COUNT≠0: go to RUN and clear the prescaler.
  - COUNT=0: ignored.
  - START in RUN: ignored.
- STOP in RUN: go to IDLE; COUNT and prescaler hold. A later START resumes from the held COUNT with the prescaler cleared.
- STOP and START in the same cycle: STOP wins.
- Prescaler, in RUN with EN=1:
  - If prescaler==PRESCALE, a tick occurs and the prescaler returns to 0.
  - Otherwise the prescaler increments.
  - PRESCALE=0 gives a tick every enabled cycle.
- EN=0: no prescaler or COUNT change; state transitions and LOAD are still honoured.
- Tick with COUNT>1: COUNT decrements by 1.
- Tick with COUNT=1 (expiry):
  - TC=1 for exactly the following cycle.
  - IRQ set to 1.
  - If AUTO_RELOAD=1 and reload≠0: COUNT=reload and stay in RUN.
  - Otherwise COUNT=0 and go to IDLE.
- Latency: START sampled at edge 0 with COUNT=N and EN held 1 gives ticks at edges k·(PRESCALE+1), and TC high after edge N·(PRESCALE+1).
- IRQ_ACK clears IRQ. Expiry in the same cycle as IRQ_ACK leaves IRQ=1 (set wins).
- COUNT never wraps below 0; there is no underflow path.
- All outputs are registered.

Optional Feature:
- Macro: COUNTDOWN_OVERRUN_EN.
- When defined:
  - Adds output OVR (1 bit, reset 0).
  - OVR is set on an expiry that occurs while IRQ is already 1.
  - OVR is cleared by IRQ_ACK; set wins on a collision.
- When undefined: the OVR port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package timer_pkg:
  - state typedef: IDLE=1'b0, RUN=1'b1
  - default WIDTH and PRESCALE_W constants
- Sub-module prescale_tick:
  - inputs: CLK, RST, clear, enable, PRESCALE
  - output: one-cycle tick
- Top level holds the FSM, COUNT, reload register and IRQ/TC logic.

Test Plan:
- Reset: RST=1 for 2 cycles mid-run with COUNT=7 → next edge COUNT=0, BUSY=0, TC=0, IRQ=0.
- One-shot: LOAD 5, PRESCALE 0, AUTO_RELOAD 0, START, EN=1 → COUNT 4,3,2,1,0 on consecutive edges; single TC pulse; BUSY drops with the last step; IRQ=1. Then IRQ_ACK → IRQ=0.
- Auto-reload: LOAD 3, PRESCALE 2, AUTO_RELOAD 1, START → TC every 9 cycles; COUNT reloads to 3; BUSY stays 1; 27 cycles give exactly 3 TC pulses.
- Pause/freeze: STOP at COUNT=2 and hold 10 cycles → COUNT=2. START → TC 2 ticks later. EN=0 during RUN → COUNT and prescaler frozen.
- Collisions:
  - LOAD 9 on the tick where COUNT=1 → COUNT=9, no TC.
  - Expiry with IRQ_ACK in the same cycle → IRQ=1.
  - STOP+START together → IDLE.
- Overrun (COUNTDOWN_OVERRUN_EN defined): two expiries with no ack → OVR=1. IRQ_ACK → IRQ=0 and OVR=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and FSM state encoding for the countdown timer.
package timer_pkg;

    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_PRESCALE_W = 8;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

endpackage

// File: rtl/prescale_tick.sv
// Enabled-cycle divider: tick is asserted on every (PRESCALE+1)th enabled cycle.
module prescale_tick
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] psc;

    // The tick is decoded from the current phase so the counter it drives
    // steps on the same edge at which the prescaler wraps.
    assign tick = enable && (psc == PRESCALE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            psc <= '0;
        end else if (clear) begin
            psc <= '0;
        end else if (tick) begin
            psc <= '0;
        end else if (enable) begin
            psc <= psc + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counting timer with prescaler, start/stop, auto-reload and sticky IRQ.
// Define COUNTDOWN_OVERRUN_EN to add the OVR output (expiry while IRQ already pending).
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  LOAD,
    input  logic [WIDTH-1:0]      LOAD_VAL,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  AUTO_RELOAD,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  IRQ_ACK,
    output logic [WIDTH-1:0]      COUNT,
    output logic                  BUSY,
    output logic                  TC,
    output logic                  IRQ
`ifdef COUNTDOWN_OVERRUN_EN
    ,
    output logic                  OVR
`endif
);

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic             start_ok;
    logic             run_en;
    logic             psc_clear;
    logic             tick;
    logic             expire;

    // LOAD and STOP both pre-empt START, and STOP/LOAD also suppress the tick.
    assign start_ok  = START && !STOP && !LOAD && (state == IDLE) && (COUNT != '0);
    assign run_en    = (state == RUN) && EN && !LOAD && !STOP;
    assign psc_clear = LOAD || start_ok;
    assign expire    = tick && (COUNT == WIDTH'(1));
    assign BUSY      = (state == RUN);

    prescale_tick #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescale (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (psc_clear),
        .enable   (run_en),
        .PRESCALE (PRESCALE),
        .tick     (tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            COUNT  <= '0;
            reload <= '0;
            TC     <= 1'b0;
        end else begin
            TC <= 1'b0;
            if (LOAD) begin
                reload <= LOAD_VAL;
                COUNT  <= LOAD_VAL;
                if (LOAD_VAL == '0) begin
                    state <= IDLE;
                end
            end else if (STOP) begin
                state <= IDLE;
            end else if (start_ok) begin
                state <= RUN;
            end else if (tick) begin
                if (expire) begin
                    TC <= 1'b1;
                    if (AUTO_RELOAD && (reload != '0)) begin
                        COUNT <= reload;
                    end else begin
                        COUNT <= '0;
                        state <= IDLE;
                    end
                end else begin
                    COUNT <= COUNT - WIDTH'(1);
                end
            end
        end
    end

    // Expiry takes precedence over an acknowledge arriving in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            IRQ <= 1'b0;
        end else if (expire) begin
            IRQ <= 1'b1;
        end else if (IRQ_ACK) begin
            IRQ <= 1'b0;
        end
    end

`ifdef COUNTDOWN_OVERRUN_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVR <= 1'b0;
        end else if (expire && IRQ) begin
            OVR <= 1'b1;
        end else if (IRQ_ACK) begin
            OVR <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus randomized traffic
// compared against a cycle-count reference model. Honours COUNTDOWN_OVERRUN_EN.
`timescale 1ns/1ps
module tb_countdown_timer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b1;
    logic        LOAD = 1'b0;
    logic [15:0] LOAD_VAL = '0;
    logic [7:0]  PRESCALE = '0;
    logic        AUTO_RELOAD = 1'b0;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic        IRQ_ACK = 1'b0;
    logic [15:0] COUNT;
    logic        BUSY;
    logic        TC;
    logic        IRQ;
`ifdef COUNTDOWN_OVERRUN_EN
    logic        OVR;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: elapsed enabled cycles since the divider was last cleared.
    int m_count, m_reload, m_elapsed;
    bit m_run, m_tc, m_irq, m_ovr;

    countdown_timer dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .LOAD        (LOAD),
        .LOAD_VAL    (LOAD_VAL),
        .PRESCALE    (PRESCALE),
        .AUTO_RELOAD (AUTO_RELOAD),
        .START       (START),
        .STOP        (STOP),
        .IRQ_ACK     (IRQ_ACK),
        .COUNT       (COUNT),
        .BUSY        (BUSY),
        .TC          (TC),
        .IRQ         (IRQ)
`ifdef COUNTDOWN_OVERRUN_EN
        ,
        .OVR         (OVR)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic model_step();
        bit expire = 1'b0;
        if (RST) begin
            m_count = 0; m_reload = 0; m_elapsed = 0;
            m_run = 0; m_tc = 0; m_irq = 0; m_ovr = 0;
            return;
        end
        m_tc = 1'b0;
        if (LOAD) begin
            m_reload = int'(LOAD_VAL);
            m_count = int'(LOAD_VAL);
            m_elapsed = 0;
            if (LOAD_VAL == 0) m_run = 1'b0;
        end else if (STOP) begin
            m_run = 1'b0;
        end else if (START && !m_run) begin
            if (m_count != 0) begin
                m_run = 1'b1;
                m_elapsed = 0;
            end
        end else if (m_run && EN) begin
            m_elapsed++;
            if (m_elapsed % (int'(PRESCALE) + 1) == 0) begin
                if (m_count == 1) begin
                    expire = 1'b1;
                    m_tc = 1'b1;
                    if (AUTO_RELOAD && m_reload != 0) begin
                        m_count = m_reload;
                    end else begin
                        m_count = 0;
                        m_run = 1'b0;
                    end
                end else begin
                    m_count--;
                end
            end
        end
        if (expire && m_irq) m_ovr = 1'b1;
        else if (IRQ_ACK) m_ovr = 1'b0;
        if (expire) m_irq = 1'b1;
        else if (IRQ_ACK) m_irq = 1'b0;
    endtask

    // One clock: update the model from the applied inputs, then sample after the edge.
    task automatic cyc();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drop_controls();
        LOAD = 0; START = 0; STOP = 0; IRQ_ACK = 0; EN = 1;
    endtask

    task automatic clean_idle();
        drop_controls();
        STOP = 1; IRQ_ACK = 1;
        cyc();
        drop_controls();
    endtask

    task automatic do_load(input int val, input int psc, input bit ar);
        LOAD = 1; LOAD_VAL = 16'(val); PRESCALE = 8'(psc); AUTO_RELOAD = ar;
        cyc();
        LOAD = 0;
    endtask

    task automatic test_reset();
        RST = 1;
        cyc(); cyc();
        RST = 0;
        n_vec++; if (COUNT !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", COUNT); end
        n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", BUSY); end
        n_vec++; if (TC !== 1'b0) begin n_err++; $display("FAIL reset_tc got %b want 0", TC); end
        n_vec++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", IRQ); end
        do_load(10, 0, 0);
        START = 1; cyc(); START = 0;
        cyc(); cyc(); cyc();
        n_vec++; if (COUNT !== 16'd7) begin n_err++; $display("FAIL midrun_count got %0d want 7", COUNT); end
        RST = 1;
        cyc();
        n_vec++; if (COUNT !== 16'd0 || BUSY !== 1'b0 || TC !== 1'b0 || IRQ !== 1'b0) begin
            n_err++; $display("FAIL midrun_reset got count=%0d busy=%b tc=%b irq=%b want 0/0/0/0", COUNT, BUSY, TC, IRQ);
        end
        cyc();
        RST = 0;
    endtask

    task automatic test_one_shot();
        int tc_cnt = 0;
        do_load(5, 0, 0);
        START = 1; cyc(); START = 0;
        n_vec++; if (BUSY !== 1'b1 || COUNT !== 16'd5) begin n_err++; $display("FAIL oneshot_start got busy=%b count=%0d want 1/5", BUSY, COUNT); end
        for (int i = 4; i >= 0; i--) begin
            cyc();
            if (TC === 1'b1) tc_cnt++;
            n_vec++; if (COUNT !== 16'(i) || BUSY !== (i != 0)) begin
                n_err++; $display("FAIL oneshot_step got count=%0d busy=%b want %0d/%b", COUNT, BUSY, i, (i != 0));
            end
        end
        cyc();
        n_vec++; if (tc_cnt != 1 || TC !== 1'b0) begin n_err++; $display("FAIL oneshot_tc got pulses=%0d tc=%b want 1/0", tc_cnt, TC); end
        n_vec++; if (IRQ !== 1'b1) begin n_err++; $display("FAIL oneshot_irq got %b want 1", IRQ); end
        IRQ_ACK = 1; cyc(); IRQ_ACK = 0;
        n_vec++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL oneshot_ack got %b want 0", IRQ); end
    endtask

    task automatic test_auto_reload();
        int tc_cnt = 0;
        int busy_low = 0;
        do_load(3, 2, 1);
        START = 1; cyc(); START = 0;
        for (int i = 1; i <= 27; i++) begin
            cyc();
            if (TC === 1'b1) tc_cnt++;
            if (BUSY !== 1'b1) busy_low++;
            n_vec++; if (TC !== (i % 9 == 0)) begin n_err++; $display("FAIL autoreload_tc cycle %0d got %b want %b", i, TC, (i % 9 == 0)); end
        end
        n_vec++; if (tc_cnt != 3 || busy_low != 0) begin n_err++; $display("FAIL autoreload_sum got pulses=%0d busy_low=%0d want 3/0", tc_cnt, busy_low); end
        n_vec++; if (COUNT !== 16'd3) begin n_err++; $display("FAIL autoreload_count got %0d want 3", COUNT); end
        clean_idle();
    endtask

    task automatic test_pause();
        do_load(5, 0, 0);
        START = 1; cyc(); START = 0;
        cyc(); cyc(); cyc();
        STOP = 1; cyc(); STOP = 0;
        repeat (10) cyc();
        n_vec++; if (COUNT !== 16'd2 || BUSY !== 1'b0) begin n_err++; $display("FAIL pause_hold got count=%0d busy=%b want 2/0", COUNT, BUSY); end
        START = 1; cyc(); START = 0;
        cyc();
        n_vec++; if (COUNT !== 16'd1 || TC !== 1'b0) begin n_err++; $display("FAIL resume_step got count=%0d tc=%b want 1/0", COUNT, TC); end
        cyc();
        n_vec++; if (COUNT !== 16'd0 || TC !== 1'b1) begin n_err++; $display("FAIL resume_tc got count=%0d tc=%b want 0/1", COUNT, TC); end
        clean_idle();
    endtask

    task automatic test_freeze();
        do_load(6, 1, 0);
        START = 1; cyc(); START = 0;
        cyc(); cyc(); cyc();
        n_vec++; if (COUNT !== 16'd5) begin n_err++; $display("FAIL freeze_pre got %0d want 5", COUNT); end
        EN = 0;
        repeat (5) cyc();
        n_vec++; if (COUNT !== 16'd5 || BUSY !== 1'b1) begin n_err++; $display("FAIL freeze_hold got count=%0d busy=%b want 5/1", COUNT, BUSY); end
        EN = 1;
        cyc();
        n_vec++; if (COUNT !== 16'd4) begin n_err++; $display("FAIL freeze_phase got %0d want 4", COUNT); end
        clean_idle();
    endtask

    task automatic test_collisions();
        do_load(2, 0, 0);
        START = 1; cyc(); START = 0;
        cyc();
        do_load(9, 0, 0);
        n_vec++; if (COUNT !== 16'd9 || TC !== 1'b0 || BUSY !== 1'b1 || IRQ !== 1'b0) begin
            n_err++; $display("FAIL load_on_expiry got count=%0d tc=%b busy=%b irq=%b want 9/0/1/0", COUNT, TC, BUSY, IRQ);
        end
        do_load(1, 0, 0);
        cyc();
        n_vec++; if (IRQ !== 1'b1 || TC !== 1'b1 || BUSY !== 1'b0) begin n_err++; $display("FAIL first_expiry got irq=%b tc=%b busy=%b want 1/1/0", IRQ, TC, BUSY); end
        do_load(1, 0, 0);
        START = 1; cyc(); START = 0;
        IRQ_ACK = 1; cyc(); IRQ_ACK = 0;
        n_vec++; if (IRQ !== 1'b1 || TC !== 1'b1) begin n_err++; $display("FAIL ack_collision got irq=%b tc=%b want 1/1", IRQ, TC); end
`ifdef COUNTDOWN_OVERRUN_EN
        n_vec++; if (OVR !== 1'b1) begin n_err++; $display("FAIL ack_collision_ovr got %b want 1", OVR); end
`endif
        IRQ_ACK = 1; cyc(); IRQ_ACK = 0;
        n_vec++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL ack_after got %b want 0", IRQ); end
        do_load(4, 0, 0);
        START = 1; STOP = 1; cyc();
        n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL stop_start_idle got busy=%b want 0", BUSY); end
        STOP = 0; cyc();
        START = 1; STOP = 1; cyc();
        n_vec++; if (BUSY !== 1'b0 || COUNT !== 16'd4) begin n_err++; $display("FAIL stop_start_run got busy=%b count=%0d want 0/4", BUSY, COUNT); end
        clean_idle();
    endtask

`ifdef COUNTDOWN_OVERRUN_EN
    task automatic test_overrun();
        do_load(1, 0, 1);
        START = 1; cyc(); START = 0;
        cyc();
        n_vec++; if (IRQ !== 1'b1 || OVR !== 1'b0) begin n_err++; $display("FAIL ovr_first got irq=%b ovr=%b want 1/0", IRQ, OVR); end
        cyc();
        n_vec++; if (OVR !== 1'b1) begin n_err++; $display("FAIL ovr_second got %b want 1", OVR); end
        STOP = 1; cyc(); STOP = 0;
        IRQ_ACK = 1; cyc(); IRQ_ACK = 0;
        n_vec++; if (IRQ !== 1'b0 || OVR !== 1'b0) begin n_err++; $display("FAIL ovr_ack got irq=%b ovr=%b want 0/0", IRQ, OVR); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            RST = ($urandom_range(0, 199) == 0);
            LOAD = ($urandom_range(0, 99) < 6);
            if (LOAD) begin
                LOAD_VAL = 16'($urandom_range(0, 6));
                PRESCALE = 8'($urandom_range(0, 3));
            end
            START = ($urandom_range(0, 99) < 20);
            STOP = ($urandom_range(0, 99) < 5);
            EN = ($urandom_range(0, 99) < 85);
            IRQ_ACK = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 99) < 3) AUTO_RELOAD = ~AUTO_RELOAD;
            cyc();
            n_vec++; if (COUNT !== 16'(m_count) || BUSY !== m_run || TC !== m_tc || IRQ !== m_irq) begin
                n_err++; $display("FAIL random cycle %0d got count=%0d busy=%b tc=%b irq=%b want %0d/%b/%b/%b",
                                  i, COUNT, BUSY, TC, IRQ, m_count, m_run, m_tc, m_irq);
            end
`ifdef COUNTDOWN_OVERRUN_EN
            n_vec++; if (OVR !== m_ovr) begin n_err++; $display("FAIL random_ovr cycle %0d got %b want %b", i, OVR, m_ovr); end
`endif
        end
        RST = 0;
        drop_controls();
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause();
        test_freeze();
        test_collisions();
`ifdef COUNTDOWN_OVERRUN_EN
        test_overrun();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
